spi_master_frame: RTL and testbench

Command-level SPI master that drives the four-wire link into the SPI slave. It accepts one 10-bit command word per request and frames it on SS_n/MOSI exactly as the slave's FSM expects. For read-data commands it also captures the 8-bit MISO reply and returns it on a parallel port. It sits between the system-side controller and the SPI pins, and is the transmit/initiator end of the existing slave link.

---
 rtl/spi_master_frame_pkg.sv | 26 ++
 rtl/spi_master_frame_shifter.sv | 32 +++
 rtl/spi_master_frame.sv | 141 ++++++++++++++
 tb/tb_spi_master_frame.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_frame_pkg.sv
// Shared types and constants for the SPI master frame controller.
// States are prefixed M_ so they never collide with the slave's state names.
package shared_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_SSL,
    M_SEL,
    M_SHIFT,
    M_WAIT,
    M_CAPT,
    M_HOLD,
    M_GAP
  } master_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int NORM_FRAME = 12;
  localparam int RD_FRAME   = 22;
  localparam int SHIFT_LEN  = 10;
  localparam int CAPT_LEN   = 8;

endpackage

// File: rtl/spi_master_frame_shifter.sv
// Datapath for the SPI master: 10-bit MSB-first transmit register and 8-bit
// MSB-first receive register, both stepped by enables from the frame FSM.
module spi_master_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] load_word,
  input  logic       shift,
  input  logic       capt,
  input  logic       miso,
  output logic       tx_msb,
  output logic [7:0] rx_byte
);

  logic [9:0] tx_reg;
  logic [7:0] rx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg <= '0;
      rx_reg <= '0;
    end else begin
      if (load)       tx_reg <= load_word;
      else if (shift) tx_reg <= {tx_reg[8:0], 1'b0};
      if (capt)       rx_reg <= {rx_reg[6:0], miso};
    end
  end

  assign tx_msb  = tx_reg[9];
  assign rx_byte = rx_reg;

endmodule

// File: rtl/spi_master_frame.sv
// Command-level SPI master: frames one 10-bit command on SS_n/MOSI and, for
// read-data commands, captures the 8-bit MISO reply. Optional: SPI_MASTER_RDSEQ_EN.
module spi_master_frame
  import shared_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] cmd_word,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       cmd_err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CW = ($clog2(IDLE_GAP) > 4) ? $clog2(IDLE_GAP) : 4;
  localparam logic [CW-1:0] GAP_LOAD   = CW'(IDLE_GAP - 1);
  localparam logic [CW-1:0] SHIFT_LOAD = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] CAPT_LOAD  = CW'(CAPT_LEN - 1);

  master_state_e state, next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    cmd_q;
  logic          load, shift, capt, rej, enter_gap, tx_msb;
  logic [7:0]    rx_byte;

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_word (cmd_word),
    .shift     (shift),
    .capt      (capt),
    .miso      (MISO),
    .tx_msb    (tx_msb),
    .rx_byte   (rx_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= M_IDLE;
      cnt   <= '0;
      cmd_q <= CMD_WR_ADDR;
    end else begin
      state <= next;
      cnt   <= cnt_next;
      if (load) cmd_q <= cmd_word[9:8];
    end
  end

  always_comb begin
    next     = state;
    cnt_next = cnt;
    load     = 1'b0;
    shift    = 1'b0;
    capt     = 1'b0;
    case (state)
      M_IDLE: if (start && !rej) begin
        load = 1'b1;
        next = M_SSL;
      end
      M_SSL: next = M_SEL;
      M_SEL: begin
        next     = M_SHIFT;
        cnt_next = SHIFT_LOAD;
      end
      M_SHIFT: begin
        shift = 1'b1;
        if (cnt == '0) begin
          next     = (cmd_q == CMD_RD_DATA) ? M_WAIT : M_GAP;
          cnt_next = (cmd_q == CMD_RD_DATA) ? CAPT_LOAD : GAP_LOAD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      M_WAIT: begin
        next     = M_CAPT;
        cnt_next = CAPT_LOAD;
      end
      M_CAPT: begin
        capt = 1'b1;
        if (cnt == '0) next = M_HOLD;
        else           cnt_next = cnt - 1'b1;
      end
      M_HOLD: begin
        next     = M_GAP;
        cnt_next = GAP_LOAD;
      end
      M_GAP: begin
        if (cnt == '0) next = M_IDLE;
        else           cnt_next = cnt - 1'b1;
      end
      default: next = M_IDLE;
    endcase
  end

  assign enter_gap = (next == M_GAP) && (state != M_GAP);
  assign busy      = (state != M_IDLE);
  assign SS_n      = (state == M_IDLE) || (state == M_GAP);
  assign MOSI      = ((state == M_SEL) || (state == M_SHIFT)) ? tx_msb : 1'b0;

  // Status pulses are registered so they line up with the first gap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      done     <= enter_gap;
      rd_valid <= enter_gap && (state == M_HOLD);
      if (enter_gap && (state == M_HOLD)) rd_data <= rx_byte;
    end
  end

`ifdef SPI_MASTER_RDSEQ_EN
  logic rd_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_seen <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      if (enter_gap && (cmd_q == CMD_RD_ADDR))      rd_seen <= 1'b1;
      else if (enter_gap && (cmd_q == CMD_RD_DATA)) rd_seen <= 1'b0;
      cmd_err <= (state == M_IDLE) && start && rej;
    end
  end

  assign rej = (cmd_word[9:8] == CMD_RD_DATA) && !rd_seen;
`else
  assign rej     = 1'b0;
  assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_frame.sv
// Scoreboard bench for spi_master_frame: stimulus pushes expected frames, a
// negedge monitor reconstructs frames from the pins and pops/compares on done.
module tb_spi_master_frame;
  import shared_pkg::*;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst, start, MISO;
  logic [9:0] cmd_word;
  logic       busy, done, rd_valid, cmd_err, SS_n, MOSI;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  spi_master_frame #(.IDLE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_word(cmd_word),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .cmd_err(cmd_err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  typedef struct {
    int          len;
    logic [21:0] mosi;
    bit          is_rd;
    logic [7:0]  rd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [7:0]  reply = 8'h00;
  logic [7:0]  last_rd = 8'h00;
  bit          cont_mode = 0, err_ok = 0, rd_seen_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: MOSI per low cycle k (index k-1): 0, selector, 10 command bits, then 0.
  function automatic exp_t model(input logic [9:0] cw, input logic [7:0] rep);
    exp_t e;
    e.is_rd = (cw[9:8] == 2'b11);
    e.len   = e.is_rd ? 22 : 12;
    e.mosi  = '0;
    e.mosi[1] = cw[9];
    for (int i = 0; i < 10; i++) e.mosi[2+i] = cw[9-i];
    e.rd = rep;
    return e;
  endfunction

  // Monitor + slave responder
  int          k = 0, hi = 0;
  logic [21:0] got = '0;
  bit          seen_frame = 0, prev_busy = 0;

  always @(negedge clk) begin
    if (rst) begin
      k = 0; hi = 0; got = '0; seen_frame = 0; prev_busy = 0; last_rd = 8'h00;
      MISO = 1'b0;
    end else begin
      if (!SS_n) begin
        if (k == 0) begin
          if (seen_frame) begin
            check("gap_min", 32'(hi >= GAP + 1), 1);
            if (cont_mode) check("gap_exact", hi, GAP + 1);
          end
          got = '0;
          hi  = 0;
        end
        k++;
        if (k <= 22) got[k-1] = MOSI;
        else check("frame_overrun", k, 22);
        check("busy_in_frame", busy, 1);
      end else begin
        hi++;
        check("mosi_idle", MOSI, 0);
        if (done) begin
          check("done_at_rise", hi, 1);
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("frame_len", k, e.len);
            check("mosi_seq", got, e.mosi);
            check("rd_valid", rd_valid, e.is_rd);
            if (e.is_rd) begin
              check("rd_data", rd_data, e.rd);
              last_rd = e.rd;
            end
          end
          seen_frame = 1;
        end else begin
          check("rd_valid_idle", rd_valid, 0);
        end
        if (seen_frame && prev_busy && !busy) check("busy_drop", hi, GAP + 1);
        k = 0;
      end
      if (!rd_valid) check("rd_data_hold", rd_data, last_rd);
      if (!err_ok) check("cmd_err_idle", cmd_err, 0);
      prev_busy = busy;
      MISO = (k >= 14 && k <= 21) ? reply[21-k] : 1'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_err(input logic [9:0] cw);
    err_ok = 1; start = 1; cmd_word = cw;
    tick();
    start = 0;
    check("cmd_err_pulse", cmd_err, 1);
    check("err_busy", busy, 0);
    check("err_ss", SS_n, 1);
    tick();
    err_ok = 0;
    check("cmd_err_single", cmd_err, 0);
    check("err_busy2", busy, 0);
  endtask

  task automatic run_frame(input logic [9:0] cw, input logic [7:0] rep,
                           input bit inject, input int extra);
    int len;
`ifdef SPI_MASTER_RDSEQ_EN
    if (cw[9:8] == 2'b11 && !rd_seen_m) begin
      run_err(cw);
      return;
    end
`endif
    reply = rep;
    q.push_back(model(cw, rep));
    start = 1; cmd_word = cw;
    tick();
    start = 0; cmd_word = 10'($urandom);
    check("busy_after_accept", busy, 1);
    len = (cw[9:8] == 2'b11) ? RD_FRAME : NORM_FRAME;
    for (int i = 0; i < len + GAP; i++) begin
      if (inject && i == 4) begin
        start = 1; cmd_word = ~cw;
      end else begin
        start = 0;
      end
      tick();
    end
    check("busy_low_after_gap", busy, 0);
    if (cw[9:8] == 2'b10) rd_seen_m = 1;
    if (cw[9:8] == 2'b11) rd_seen_m = 0;
    repeat (extra) tick();
  endtask

  initial begin
    logic [9:0] cw;
    rst = 1; start = 0; cmd_word = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst = 0;
    tick();

`ifdef SPI_MASTER_RDSEQ_EN
    run_err({2'b11, 8'h3C});
`endif
    run_frame(10'b01_1010_0101, 8'h00, 0, 0);
    run_frame({2'b10, 8'h5A}, 8'h00, 0, 0);
    run_frame({2'b11, 8'h00}, 8'hC3, 0, 1);
    run_frame({2'b00, 8'h96}, 8'h00, 1, 2);

    // Reset mid-shift: frame is discarded, no done expected.
    cw = {2'b10, 8'($urandom)};
    start = 1; cmd_word = cw;
    tick();
    start = 0;
    repeat (5) tick();
    rst = 1;
    #1;
    check("midrst_ss", SS_n, 1);
    check("midrst_mosi", MOSI, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tick(); tick();
    rst = 0; rd_seen_m = 0;
    tick();
`ifdef SPI_MASTER_RDSEQ_EN
    run_frame({2'b11, 8'h11}, 8'h77, 0, 0);
`endif
    run_frame({2'b01, 8'($urandom)}, 8'h00, 0, 0);

    // start held high: back-to-back frames with minimum gap.
    cw = {2'b00, 8'($urandom)};
    q.push_back(model(cw, 8'h00));
    q.push_back(model(cw, 8'h00));
    start = 1; cmd_word = cw;
    tick(); tick();
    cont_mode = 1;
    repeat (NORM_FRAME + 1 + GAP - 2) tick();
    tick();
    start = 0;
    check("cont_busy", busy, 1);
    repeat (NORM_FRAME + GAP) tick();
    cont_mode = 0;
    check("cont_busy_low", busy, 0);

    for (int n = 0; n < 40; n++) begin
      run_frame(10'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 2)));
    end

    repeat (5) tick();
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
